// File: rtl/cbfp_pingpong_norm.sv
`default_nettype none
// cbfp_pingpong_norm: ping-pong buffered convergent block-floating-point normaliser.
// Macro CBFP_ROUND_EN selects round-half-up with saturation; otherwise outputs are truncated.
module cbfp_pingpong_norm #(
  parameter int LANES  = 16,
  parameter int BEATS  = 4,
  parameter int DIN_W  = 23,
  parameter int DOUT_W = 11,
  parameter int EXP_W  = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    valid_in,
  input  logic [LANES*DIN_W-1:0]  din_re,
  input  logic [LANES*DIN_W-1:0]  din_im,
  output logic                    valid_out,
  output logic                    sof_out,
  output logic [LANES*DOUT_W-1:0] dout_re,
  output logic [LANES*DOUT_W-1:0] dout_im,
  output logic [EXP_W-1:0]        blk_exp
);

  localparam int SH = DIN_W - DOUT_W;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [EXP_W-1:0] MAXC = EXP_W'(DIN_W - 1);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

  // Redundant sign bits below the MSB, 0..DIN_W-1.
  function automatic logic [EXP_W-1:0] cnt_sign(input logic [DIN_W-1:0] x);
    logic [EXP_W-1:0] n;
    logic run;
    n   = '0;
    run = 1'b1;
    for (int i = DIN_W - 2; i >= 0; i--) begin
      if (run && (x[i] == x[DIN_W-1])) n = n + EXP_W'(1);
      else run = 1'b0;
    end
    return n;
  endfunction

  function automatic logic [DOUT_W-1:0] norm(input logic signed [DIN_W-1:0] x,
                                             input logic [EXP_W-1:0] s);
    logic signed [DIN_W-1:0] sh;
`ifdef CBFP_ROUND_EN
    logic signed [DIN_W:0] r;
    sh = x <<< s;
    r  = {sh[DIN_W-1], sh} + (DIN_W+1)'(1 << (SH - 1));
    r  = r >>> SH;
    if (r > $signed((DIN_W+1)'((1 << (DOUT_W - 1)) - 1)))
      r = $signed((DIN_W+1)'((1 << (DOUT_W - 1)) - 1));
    else if (r < -$signed((DIN_W+1)'(1 << (DOUT_W - 1))))
      r = -$signed((DIN_W+1)'(1 << (DOUT_W - 1)));
    return r[DOUT_W-1:0];
`else
    logic signed [DIN_W-1:0] t;
    sh = x <<< s;
    t  = sh >>> SH;
    return t[DOUT_W-1:0];
`endif
  endfunction

  // ---------------- write side ----------------
  logic [LANES*DIN_W-1:0] mem_re_q [2][BEATS];
  logic [LANES*DIN_W-1:0] mem_re_d [2][BEATS];
  logic [LANES*DIN_W-1:0] mem_im_q [2][BEATS];
  logic [LANES*DIN_W-1:0] mem_im_d [2][BEATS];
  logic [BW-1:0]    wbeat_q, wbeat_d;
  logic             wbank_q, wbank_d;
  logic [EXP_W-1:0] min_q, min_d;
  logic [EXP_W-1:0] exp_q [2];
  logic [EXP_W-1:0] exp_d [2];
  logic             done_q, done_d;
  logic             done_bank_q, done_bank_d;
  logic [EXP_W-1:0] beat_min, cur_min, c_re, c_im;

  always_comb begin
    beat_min = MAXC;
    c_re     = '0;
    c_im     = '0;
    for (int l = 0; l < LANES; l++) begin
      c_re = cnt_sign(din_re[l*DIN_W +: DIN_W]);
      c_im = cnt_sign(din_im[l*DIN_W +: DIN_W]);
      if (c_re < beat_min) beat_min = c_re;
      if (c_im < beat_min) beat_min = c_im;
    end
    cur_min = (beat_min < min_q) ? beat_min : min_q;
  end

  always_comb begin
    mem_re_d    = mem_re_q;
    mem_im_d    = mem_im_q;
    wbeat_d     = wbeat_q;
    wbank_d     = wbank_q;
    min_d       = min_q;
    exp_d       = exp_q;
    done_d      = 1'b0;
    done_bank_d = done_bank_q;
    if (valid_in) begin
      mem_re_d[wbank_q][wbeat_q] = din_re;
      mem_im_d[wbank_q][wbeat_q] = din_im;
      if (wbeat_q == LAST) begin
        exp_d[wbank_q] = cur_min;
        wbank_d        = ~wbank_q;
        wbeat_d        = '0;
        min_d          = MAXC;
        done_d         = 1'b1;
        done_bank_d    = wbank_q;
      end else begin
        wbeat_d = wbeat_q + BW'(1);
        min_d   = cur_min;
      end
    end
  end

  // Sample storage carries no reset: contents are only read after a full block is written.
  always_ff @(posedge clk) begin
    mem_re_q <= mem_re_d;
    mem_im_q <= mem_im_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbeat_q     <= '0;
      wbank_q     <= 1'b0;
      min_q       <= MAXC;
      exp_q[0]    <= '0;
      exp_q[1]    <= '0;
      done_q      <= 1'b0;
      done_bank_q <= 1'b0;
    end else begin
      wbeat_q     <= wbeat_d;
      wbank_q     <= wbank_d;
      min_q       <= min_d;
      exp_q       <= exp_d;
      done_q      <= done_d;
      done_bank_q <= done_bank_d;
    end
  end

  // ---------------- read side ----------------
  state_t                  state_q, state_d;
  logic [BW-1:0]           rbeat_q, rbeat_d;
  logic                    rbank_q, rbank_d;
  logic                    valid_q, valid_d, sof_q, sof_d;
  logic [EXP_W-1:0]        bexp_q, bexp_d;
  logic [LANES*DOUT_W-1:0] dre_q, dre_d, dim_q, dim_d;
  logic [LANES*DIN_W-1:0]  rd_re, rd_im;
  logic                    start, advance;

  always_comb begin
    state_d = state_q;
    rbeat_d = rbeat_q;
    rbank_d = rbank_q;
    bexp_d  = bexp_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    dre_d   = dre_q;
    dim_d   = dim_q;
    start   = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: if (done_q) start = 1'b1;
      READ: begin
        if (rbeat_q != LAST) advance = 1'b1;
        else if (done_q)     start   = 1'b1;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A block finishing on the last read beat chains straight into the next block.
    if (start) begin
      state_d = READ;
      rbeat_d = '0;
      rbank_d = done_bank_q;
      bexp_d  = exp_q[done_bank_q];
      valid_d = 1'b1;
      sof_d   = 1'b1;
    end
    if (advance) begin
      rbeat_d = rbeat_q + BW'(1);
      valid_d = 1'b1;
    end
    rd_re = mem_re_q[rbank_d][rbeat_d];
    rd_im = mem_im_q[rbank_d][rbeat_d];
    if (valid_d) begin
      for (int l = 0; l < LANES; l++) begin
        dre_d[l*DOUT_W +: DOUT_W] = norm(rd_re[l*DIN_W +: DIN_W], bexp_d);
        dim_d[l*DOUT_W +: DOUT_W] = norm(rd_im[l*DIN_W +: DIN_W], bexp_d);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rbeat_q <= '0;
      rbank_q <= 1'b0;
      bexp_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      dre_q   <= '0;
      dim_q   <= '0;
    end else begin
      state_q <= state_d;
      rbeat_q <= rbeat_d;
      rbank_q <= rbank_d;
      bexp_q  <= bexp_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      dre_q   <= dre_d;
      dim_q   <= dim_d;
    end
  end

  assign valid_out = valid_q;
  assign sof_out   = sof_q;
  assign dout_re   = dre_q;
  assign dout_im   = dim_q;
  assign blk_exp   = bexp_q;

endmodule
`default_nettype wire

// File: tb/tb_cbfp_pingpong_norm.sv
`default_nettype none
// tb_cbfp_pingpong_norm: scoreboard bench with an arithmetic reference model of the CBFP normaliser.
module tb_cbfp_pingpong_norm;
  localparam int LANES = 16, BEATS = 4, DIN_W = 23, DOUT_W = 11, EXP_W = 5;
  localparam int SH = DIN_W - DOUT_W;

  logic clk = 1'b0, rstn = 1'b0, valid_in = 1'b0;
  logic [LANES*DIN_W-1:0]  din_re = '0, din_im = '0;
  logic                    valid_out, sof_out;
  logic [LANES*DOUT_W-1:0] dout_re, dout_im;
  logic [EXP_W-1:0]        blk_exp;

  always #5 clk = ~clk;

  cbfp_pingpong_norm #(.LANES(LANES), .BEATS(BEATS), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .EXP_W(EXP_W)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
    .valid_out(valid_out), .sof_out(sof_out), .dout_re(dout_re), .dout_im(dout_im), .blk_exp(blk_exp));

  typedef struct {
    logic [LANES*DOUT_W-1:0] re;
    logic [LANES*DOUT_W-1:0] im;
    logic [EXP_W-1:0]        e;
    bit                      sof;
    bit                      last;
  } exp_t;

  exp_t   sbq[$];
  exp_t   mon_e;
  int     n_cmp = 0, n_bad = 0;
  longint cur_re[LANES], cur_im[LANES];
  longint blk_re[BEATS][LANES], blk_im[BEATS][LANES];
  int     nb = 0, cyc = 0, in_edge = 0, run = 0, max_run = 0;
  bit     lat_arm = 0, lat_pend = 0, in_blk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Largest left shift that keeps x representable in DIN_W signed bits.
  function automatic int cexp(input longint x);
    longint v;
    for (int k = DIN_W - 1; k > 0; k--) begin
      v = x * (longint'(1) << k);
      if (v >= -(longint'(1) << (DIN_W - 1)) && v <= (longint'(1) << (DIN_W - 1)) - 1) return k;
    end
    return 0;
  endfunction

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint outv(input longint x, input int s);
    longint v, d, y;
    v = x * (longint'(1) << s);
    d = longint'(1) << SH;
`ifdef CBFP_ROUND_EN
    y = fdiv(v + d / 2, d);
    if (y > (longint'(1) << (DOUT_W - 1)) - 1) y = (longint'(1) << (DOUT_W - 1)) - 1;
    if (y < -(longint'(1) << (DOUT_W - 1)))    y = -(longint'(1) << (DOUT_W - 1));
`else
    y = fdiv(v, d);
`endif
    return y;
  endfunction

  task automatic push_block();
    int s;
    exp_t e;
    logic [63:0] t;
    s = DIN_W - 1;
    for (int b = 0; b < BEATS; b++)
      for (int l = 0; l < LANES; l++) begin
        if (cexp(blk_re[b][l]) < s) s = cexp(blk_re[b][l]);
        if (cexp(blk_im[b][l]) < s) s = cexp(blk_im[b][l]);
      end
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < LANES; l++) begin
        t = outv(blk_re[b][l], s);
        e.re[l*DOUT_W +: DOUT_W] = t[DOUT_W-1:0];
        t = outv(blk_im[b][l], s);
        e.im[l*DOUT_W +: DOUT_W] = t[DOUT_W-1:0];
      end
      e.e    = EXP_W'(s);
      e.sof  = (b == 0);
      e.last = (b == BEATS - 1);
      sbq.push_back(e);
    end
  endtask

  task automatic drive(input bit v);
    @(negedge clk);
    valid_in = v;
    for (int l = 0; l < LANES; l++) begin
      din_re[l*DIN_W +: DIN_W] = DIN_W'(cur_re[l]);
      din_im[l*DIN_W +: DIN_W] = DIN_W'(cur_im[l]);
    end
    if (v) begin
      if (lat_arm) begin
        in_edge  = cyc + 1;
        lat_pend = 1;
        lat_arm  = 0;
      end
      for (int l = 0; l < LANES; l++) begin
        blk_re[nb][l] = cur_re[l];
        blk_im[nb][l] = cur_im[l];
      end
      nb++;
      if (nb == BEATS) begin
        push_block();
        nb = 0;
      end
    end
  endtask

  task automatic set_all(input longint re, input longint im);
    for (int l = 0; l < LANES; l++) begin
      cur_re[l] = re;
      cur_im[l] = im;
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    @(negedge clk);
    valid_in = 1'b0;
    while (sbq.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    chk("drain_pending_beats", 256'(sbq.size()), 256'(0));
    sbq.delete();
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rstn     = 1'b0;
    valid_in = 1'b0;
    nb       = 0;
    lat_pend = 0;
    sbq.delete();
    repeat (cycles) begin
      #1;
      chk("reset_valid_out", 256'(valid_out), 256'(0));
      chk("reset_sof_out", 256'(sof_out), 256'(0));
      chk("reset_blk_exp", 256'(blk_exp), 256'(0));
      chk("reset_dout_re", 256'(dout_re), 256'(0));
      chk("reset_dout_im", 256'(dout_im), 256'(0));
      @(negedge clk);
    end
    rstn = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rstn) begin
      in_blk = 0;
      run    = 0;
    end else begin
      run = valid_out ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (in_blk && !valid_out) begin
        n_cmp++;
        n_bad++;
        $display("FAIL block_gap: valid_out=0 required 1");
        in_blk = 0;
      end
      if (valid_out) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: valid_out=1 required 0");
        end else begin
          mon_e = sbq.pop_front();
          chk("blk_exp", 256'(blk_exp), 256'(mon_e.e));
          chk("sof_out", 256'(sof_out), 256'(mon_e.sof));
          chk("dout_re", 256'(dout_re), 256'(mon_e.re));
          chk("dout_im", 256'(dout_im), 256'(mon_e.im));
          in_blk = !mon_e.last;
          if (lat_pend) begin
            chk("first_out_latency", 256'(cyc + 1 - in_edge), 256'(BEATS + 1));
            lat_pend = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DIN_W-1:0] t;
    int kb, kr;
    do_reset(3);

    // all +1: s=21, outputs 512, latency BEATS+1
    lat_arm = 1;
    set_all(1, 1);
    repeat (4) drive(1);
    wait_drain();

    // most negative sample forces s=0
    set_all(1, 1);
    cur_re[5] = -4194304;
    drive(1);
    cur_re[5] = 1;
    repeat (3) drive(1);
    wait_drain();

    // most positive sample: truncates to 1023, rounds and saturates to 1023
    set_all(0, 0);
    cur_im[9] = 4194303;
    drive(1);
    cur_im[9] = 0;
    repeat (3) drive(1);
    wait_drain();

    // back-to-back blocks must give one contiguous 8-beat output run
    max_run = 0;
    set_all(1, 1);
    repeat (4) drive(1);
    set_all(0, 0);
    repeat (4) drive(1);
    wait_drain();
    chk("back_to_back_run", 256'(max_run), 256'(8));

    // valid_in toggling every other cycle
    set_all(256, 256);
    repeat (4) begin
      drive(1);
      drive(0);
    end
    wait_drain();

    // reset mid-block discards the partial block
    set_all(1, 1);
    drive(1);
    drive(1);
    do_reset(2);
    set_all(1, 1);
    repeat (4) drive(1);
    wait_drain();

    // randomized blocks with random valid gaps and magnitudes
    for (int blk = 0; blk < 40; blk++) begin
      kb = $urandom_range(0, DIN_W - 1);
      for (int b = 0; b < BEATS; b++) begin
        for (int l = 0; l < LANES; l++) begin
          kr = kb + $urandom_range(0, 2);
          if (kr > DIN_W - 1) kr = DIN_W - 1;
          t = DIN_W'($urandom);
          cur_re[l] = (blk % 9 == 8) ? 0 : longint'(t >>> kr);
          t = DIN_W'($urandom);
          cur_im[l] = (blk % 9 == 8) ? 0 : longint'(t >>> kr);
        end
        while ($urandom_range(0, 9) < 3) drive(0);
        drive(1);
      end
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
